ws2812b_frame_streamer: RTL and testbench

Parametrised successor to the fixed 36-LED, 1-bit-per-colour frame generator. On each frame tick it fetches LED_COUNT pixels of full 8-bit colour from the byte-wide SRAM read port (RAM_IS61WV6416BLL r_* handshake) and applies a global brightness scale. It reorders the bytes to the strip's wire order and hands one word per LED to ws2812b_out_module over the bitstream_available/bitstream_read handshake. It prefetches the next pixel while the current one is being shifted out, and supports RGB or RGBW strips.

---
 rtl/ws2812b_pkg.sv | 23 ++
 rtl/ws2812b_pixel_fetch.sv | 120 ++++++++++++
 rtl/ws2812b_frame_streamer.sv | 172 +++++++++++++++++
 tb/tb_ws2812b_frame_streamer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812b_pkg.sv
// ==== ws2812b_pkg : shared WS2812B streamer types, constants and brightness scaling ====
// Rev 1.0
`default_nettype none

package ws2812b_pkg;

   localparam int ORDER_GRB         = 0;
   localparam int ORDER_RGB         = 1;
   localparam int MAX_BYTES_PER_LED = 4;

   typedef enum logic [1:0] {FR_IDLE, FR_FETCH, FR_HOLD, FR_DRAIN} frame_state_e;
   typedef enum logic [1:0] {PX_IDLE, PX_REQ, PX_GAP, PX_VALID}   pixel_state_e;

   // (c * (b + 1)) >> 8 : b = 0xFF is identity, b = 0x00 blanks the channel.
   function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
      logic [15:0] prod;
      prod = {8'd0, c} * ({8'd0, b} + 16'd1);
      return prod[15:8];
   endfunction

endpackage

`default_nettype wire

// File: rtl/ws2812b_pixel_fetch.sv
// ==== ws2812b_pixel_fetch : reads one pixel byte-by-byte, scales it and reorders it to wire order ====
// Rev 1.0
`default_nettype none

module ws2812b_pixel_fetch
   import ws2812b_pkg::*;
#(
   parameter int BYTES_PER_LED = 3,
   parameter int ADDR_WIDTH    = 17,
   parameter int COLOR_ORDER   = ORDER_GRB
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       load_i,
   input  logic [ADDR_WIDTH-1:0]      base_addr_i,
   input  logic                       start_i,
   input  logic [7:0]                 brightness_i,
   output logic                       idle_o,
   output logic [ADDR_WIDTH-1:0]      r_address_o,
   output logic                       r_request_o,
   input  logic                       r_done_i,
   input  logic [7:0]                 r_data_i,
   output logic [8*BYTES_PER_LED-1:0] word_o,
   output logic                       valid_o,
   input  logic                       ack_i
);

   localparam int         WW       = 8*BYTES_PER_LED;
   localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_LED-1);

   pixel_state_e                        state_q, state_d;
   logic [1:0]                          idx_q, idx_d;
   logic [ADDR_WIDTH-1:0]               next_addr_q, next_addr_d;
   logic [ADDR_WIDTH-1:0]               addr_q, addr_d;
   logic                                req_q, req_d;
   logic [BYTES_PER_LED-1:0][7:0]       bytes_q, bytes_d;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      next_addr_d = next_addr_q;
      addr_d      = addr_q;
      req_d       = req_q;
      bytes_d     = bytes_q;
      if (load_i)
         next_addr_d = base_addr_i;
      case (state_q)
         PX_IDLE: begin
            if (start_i) begin
               addr_d      = next_addr_q;
               next_addr_d = next_addr_q + ADDR_WIDTH'(1);
               req_d       = 1'b1;
               idx_d       = 2'd0;
               state_d     = PX_REQ;
            end
         end
         PX_REQ: begin
            if (r_done_i) begin
               bytes_d[idx_q] = scale8(r_data_i, brightness_i);
               req_d          = 1'b0;
               if (idx_q == LAST_IDX) begin
                  state_d = PX_VALID;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = PX_GAP;
               end
            end
         end
         // One idle cycle between consecutive SRAM requests.
         PX_GAP: begin
            addr_d      = next_addr_q;
            next_addr_d = next_addr_q + ADDR_WIDTH'(1);
            req_d       = 1'b1;
            state_d     = PX_REQ;
         end
         PX_VALID: begin
            if (ack_i)
               state_d = PX_IDLE;
         end
         default: state_d = PX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= PX_IDLE;
         idx_q       <= 2'd0;
         next_addr_q <= '0;
         addr_q      <= '0;
         req_q       <= 1'b0;
         bytes_q     <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         next_addr_q <= next_addr_d;
         addr_q      <= addr_d;
         req_q       <= req_d;
         bytes_q     <= bytes_d;
      end
   end

   // RAM order is R,G,B(,W); GRB wire order swaps the first two bytes, W always stays last.
   always_comb begin
      word_o = '0;
      for (int k = 0; k < BYTES_PER_LED; k++)
         word_o[8*(BYTES_PER_LED-1-k) +: 8] = bytes_q[k];
      if (COLOR_ORDER == ORDER_GRB) begin
         word_o[WW-1 -: 8] = bytes_q[1];
         word_o[WW-9 -: 8] = bytes_q[0];
      end
   end

   assign idle_o      = (state_q == PX_IDLE);
   assign valid_o     = (state_q == PX_VALID);
   assign r_address_o = addr_q;
   assign r_request_o = req_q;

endmodule

`default_nettype wire

// File: rtl/ws2812b_frame_streamer.sv
// ==== ws2812b_frame_streamer : per-frame SRAM pixel fetch into a prefetched word stream for ws2812b_out_module ====
// Rev 1.0
`default_nettype none

module ws2812b_frame_streamer
   import ws2812b_pkg::*;
#(
   parameter int LED_COUNT     = 36,
   parameter int BYTES_PER_LED = 3,
   parameter int ADDR_WIDTH    = 17,
   parameter int BASE_ADDR     = 0,
   parameter int COLOR_ORDER   = ORDER_GRB
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       frame_start,
   input  logic [7:0]                 brightness,
   output logic [ADDR_WIDTH-1:0]      r_address,
   output logic                       r_request,
   input  logic                       r_done,
   input  logic [7:0]                 r_data,
   output logic [8*BYTES_PER_LED-1:0] bitstream,
   output logic                       bitstream_available,
   input  logic                       bitstream_read,
   output logic                       busy,
   output logic                       frame_done,
   output logic                       frame_overrun
);

   localparam int            WW       = 8*BYTES_PER_LED;
   localparam int            CW       = $clog2(LED_COUNT+1);
   localparam logic [CW-1:0] LAST_CNT = CW'(LED_COUNT);

   frame_state_e   state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [7:0]     bright_q, bright_d;
   logic [WW-1:0]  out_q, out_d, pf_q, pf_d;
   logic           out_vld_q, out_vld_d, pf_vld_q, pf_vld_d;
   logic           busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;

   logic           take, out_free;
   logic           f_load, f_start, f_idle, f_valid, f_ack;
   logic [WW-1:0]  f_word;

   ws2812b_pixel_fetch #(
      .BYTES_PER_LED (BYTES_PER_LED),
      .ADDR_WIDTH    (ADDR_WIDTH),
      .COLOR_ORDER   (COLOR_ORDER)
   ) u_fetch (
      .clk          (clk),
      .resetn       (resetn),
      .load_i       (f_load),
      .base_addr_i  (ADDR_WIDTH'(BASE_ADDR)),
      .start_i      (f_start),
      .brightness_i (bright_q),
      .idle_o       (f_idle),
      .r_address_o  (r_address),
      .r_request_o  (r_request),
      .r_done_i     (r_done),
      .r_data_i     (r_data),
      .word_o       (f_word),
      .valid_o      (f_valid),
      .ack_i        (f_ack)
   );

   assign take     = bitstream_read && out_vld_q;
   assign out_free = !out_vld_q || take;
   assign f_ack    = f_valid && (out_free || !pf_vld_q);
   assign f_load   = (state_q == FR_IDLE) && frame_start;
   assign f_start  = (state_q == FR_FETCH) && f_idle && (cnt_q != LAST_CNT);

   // Output/prefetch pair: the prefetch slot fills only while the output register is occupied.
   always_comb begin
      out_d     = out_q;
      out_vld_d = out_vld_q;
      pf_d      = pf_q;
      pf_vld_d  = pf_vld_q;
      if (out_free) begin
         if (pf_vld_q) begin
            out_d     = pf_q;
            out_vld_d = 1'b1;
            pf_vld_d  = f_ack;
            if (f_ack)
               pf_d = f_word;
         end else if (f_ack) begin
            out_d     = f_word;
            out_vld_d = 1'b1;
         end else begin
            out_vld_d = 1'b0;
         end
      end else if (f_ack) begin
         pf_d     = f_word;
         pf_vld_d = 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bright_d = bright_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      ovr_d    = ovr_q;
      if (frame_start && (state_q != FR_IDLE))
         ovr_d = 1'b1;
      if (f_start)
         cnt_d = cnt_q + CW'(1);
      case (state_q)
         FR_IDLE: begin
            if (frame_start) begin
               bright_d = brightness;
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = FR_FETCH;
            end
         end
         FR_FETCH: begin
            if (f_ack && (cnt_q == LAST_CNT))
               state_d = FR_DRAIN;
            else if (f_valid && !f_ack)
               state_d = FR_HOLD;
         end
         FR_HOLD: begin
            if (f_ack)
               state_d = (cnt_q == LAST_CNT) ? FR_DRAIN : FR_FETCH;
         end
         FR_DRAIN: begin
            if (take && !pf_vld_q) begin
               state_d = FR_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = FR_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= FR_IDLE;
         cnt_q     <= '0;
         bright_q  <= 8'd0;
         out_q     <= '0;
         out_vld_q <= 1'b0;
         pf_q      <= '0;
         pf_vld_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bright_q  <= bright_d;
         out_q     <= out_d;
         out_vld_q <= out_vld_d;
         pf_q      <= pf_d;
         pf_vld_q  <= pf_vld_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ovr_q     <= ovr_d;
      end
   end

   assign bitstream           = out_q;
   assign bitstream_available = out_vld_q;
   assign busy                = busy_q;
   assign frame_done          = done_q;
   assign frame_overrun       = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_ws2812b_frame_streamer.sv
// ==== tb_ws2812b_frame_streamer : directed bench, one RGB/GRB instance and one RGBW/RGB instance ====
// Rev 1.0
`default_nettype none

module tb_ws2812b_frame_streamer;

   localparam int AW = 17;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   // Instance A: 2 LEDs, RGB strip, GRB wire order, base 0
   logic          a_start, a_req, a_done, a_avail, a_read, a_busy, a_fdone, a_ovr;
   logic [7:0]    a_bright, a_data;
   logic [AW-1:0] a_addr;
   logic [23:0]   a_bits;
   // Instance B: 1 LED, RGBW strip, RGB wire order, base 4
   logic          b_start, b_req, b_done, b_avail, b_read, b_busy, b_fdone, b_ovr;
   logic [7:0]    b_bright, b_data;
   logic [AW-1:0] b_addr;
   logic [31:0]   b_bits;

   ws2812b_frame_streamer #(
      .LED_COUNT(2), .BYTES_PER_LED(3), .ADDR_WIDTH(AW), .BASE_ADDR(0), .COLOR_ORDER(0)
   ) dut_a (
      .clk(clk), .resetn(resetn), .frame_start(a_start), .brightness(a_bright),
      .r_address(a_addr), .r_request(a_req), .r_done(a_done), .r_data(a_data),
      .bitstream(a_bits), .bitstream_available(a_avail), .bitstream_read(a_read),
      .busy(a_busy), .frame_done(a_fdone), .frame_overrun(a_ovr)
   );

   ws2812b_frame_streamer #(
      .LED_COUNT(1), .BYTES_PER_LED(4), .ADDR_WIDTH(AW), .BASE_ADDR(4), .COLOR_ORDER(1)
   ) dut_b (
      .clk(clk), .resetn(resetn), .frame_start(b_start), .brightness(b_bright),
      .r_address(b_addr), .r_request(b_req), .r_done(b_done), .r_data(b_data),
      .bitstream(b_bits), .bitstream_available(b_avail), .bitstream_read(b_read),
      .busy(b_busy), .frame_done(b_fdone), .frame_overrun(b_ovr)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // SRAM models: r_done pulses a_lat negedges after the request is seen.
   logic [7:0]    mem_a [0:15];
   logic [7:0]    mem_b [0:15];
   logic [AW-1:0] a_log [$];
   logic [AW-1:0] b_log [$];
   int            a_lat = 1;

   initial begin
      int cnt;
      cnt = 0;
      a_done = 1'b0;
      a_data = 8'd0;
      forever begin
         @(negedge clk);
         if (a_done) begin
            a_done = 1'b0;
         end else if (a_req) begin
            cnt++;
            if (cnt >= a_lat) begin
               a_done = 1'b1;
               a_data = mem_a[a_addr[3:0]];
               a_log.push_back(a_addr);
               cnt = 0;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   initial begin
      b_done = 1'b0;
      b_data = 8'd0;
      forever begin
         @(negedge clk);
         if (b_done) begin
            b_done = 1'b0;
         end else if (b_req) begin
            b_done = 1'b1;
            b_data = mem_b[b_addr[3:0]];
            b_log.push_back(b_addr);
         end
      end
   end

   // gapexp: -1 no check, else expected available right after the first word is taken.
   task automatic a_frame(input logic [7:0] br, input int dly, input bit poke, input int gapexp,
                          input logic [23:0] e0, input logic [23:0] e1);
      int          k;
      logic [23:0] e;
      a_log.delete();
      @(negedge clk);
      a_bright = br;
      a_start  = 1'b1;
      @(negedge clk);
      a_start  = 1'b0;
      chk("busy_set", {31'd0, a_busy}, 32'd1);
      if (poke) begin
         a_start = 1'b1;
         @(negedge clk);
         a_start = 1'b0;
         chk("overrun_set", {31'd0, a_ovr}, 32'd1);
      end
      for (int w = 0; w < 2; w++) begin
         e = (w == 0) ? e0 : e1;
         k = 0;
         while (!a_avail && k < 400) begin
            @(negedge clk);
            k++;
         end
         chk("avail", {31'd0, a_avail}, 32'd1);
         if (w == 0 && !poke)
            chk("latency", {31'd0, (k + 1) <= (1 + 3*(a_lat + 1) + 2)}, 32'd1);
         chk("word", {8'd0, a_bits}, {8'd0, e});
         for (int d = 0; d < dly; d++) begin
            @(negedge clk);
            chk("hold", {7'd0, a_avail, a_bits}, {7'd0, 1'b1, e});
         end
         a_read = 1'b1;
         @(negedge clk);
         a_read = 1'b0;
         if (w == 0 && gapexp >= 0)
            chk("avail_after_take", {31'd0, a_avail}, gapexp);
      end
      chk("frame_done", {31'd0, a_fdone}, 32'd1);
      chk("busy_clr", {31'd0, a_busy}, 32'd0);
      @(negedge clk);
      chk("frame_done_pulse", {31'd0, a_fdone}, 32'd0);
      chk("nreads", a_log.size(), 32'd6);
      for (int i = 0; i < 6 && i < a_log.size(); i++)
         chk("addr", {15'd0, a_log[i]}, i);
   endtask

   initial begin
      int k;
      resetn   = 1'b0;
      a_start  = 1'b0; a_read = 1'b0; a_bright = 8'd0;
      b_start  = 1'b0; b_read = 1'b0; b_bright = 8'd0;
      for (int i = 0; i < 16; i++) begin
         mem_a[i] = 8'h00;
         mem_b[i] = 8'h00;
      end
      repeat (3) @(negedge clk);
      chk("rst_req",   {31'd0, a_req},   32'd0);
      chk("rst_avail", {31'd0, a_avail}, 32'd0);
      chk("rst_busy",  {31'd0, a_busy},  32'd0);
      chk("rst_done",  {31'd0, a_fdone}, 32'd0);
      chk("rst_ovr",   {31'd0, a_ovr},   32'd0);
      chk("rst_bits",  {8'd0, a_bits},   32'd0);
      chk("rst_b_avail", {31'd0, b_avail}, 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      // Identity brightness, GRB reorder, slow consumer
      mem_a[0] = 8'h11; mem_a[1] = 8'h22; mem_a[2] = 8'h33;
      mem_a[3] = 8'h44; mem_a[4] = 8'h55; mem_a[5] = 8'h66;
      a_frame(8'hFF, 3, 1'b0, -1, 24'h221133, 24'h554466);

      // Scaling: 0x80 * 0x80 >> 8 = 0x40; very slow consumer keeps the prefetch full
      for (int i = 0; i < 6; i++) mem_a[i] = 8'h80;
      a_frame(8'h7F, 20, 1'b0, 1, 24'h404040, 24'h404040);
      a_frame(8'h00, 2, 1'b0, -1, 24'h000000, 24'h000000);

      // Slow SRAM, consumer acks at once: available must drop between words
      mem_a[0] = 8'h11; mem_a[1] = 8'h22; mem_a[2] = 8'h33;
      mem_a[3] = 8'h44; mem_a[4] = 8'h55; mem_a[5] = 8'h66;
      a_lat = 4;
      a_frame(8'hFF, 0, 1'b0, 0, 24'h221133, 24'h554466);
      a_lat = 1;

      // frame_start while busy: ignored, overrun sticks across the next frame
      mem_a[0] = 8'hA0; mem_a[1] = 8'hB1; mem_a[2] = 8'hC2;
      a_frame(8'hFF, 1, 1'b1, -1, 24'hB1A0C2, 24'h554466);
      chk("overrun_held", {31'd0, a_ovr}, 32'd1);
      a_frame(8'hFF, 1, 1'b0, -1, 24'hB1A0C2, 24'h554466);
      chk("overrun_held2", {31'd0, a_ovr}, 32'd1);

      // One-cycle reset while a request is outstanding
      @(negedge clk);
      a_bright = 8'hFF;
      a_start  = 1'b1;
      @(negedge clk);
      a_start  = 1'b0;
      k = 0;
      while (!a_req && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("req_seen", {31'd0, a_req}, 32'd1);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      chk("abort_req",   {31'd0, a_req},   32'd0);
      chk("abort_avail", {31'd0, a_avail}, 32'd0);
      chk("abort_busy",  {31'd0, a_busy},  32'd0);
      chk("abort_ovr",   {31'd0, a_ovr},   32'd0);
      repeat (2) @(negedge clk);
      a_frame(8'hFF, 1, 1'b0, -1, 24'hB1A0C2, 24'h554466);

      // RGBW, RGB wire order, single-LED frame at base 4
      mem_b[4] = 8'h01; mem_b[5] = 8'h02; mem_b[6] = 8'h03; mem_b[7] = 8'h04;
      b_log.delete();
      @(negedge clk);
      b_bright = 8'hFF;
      b_start  = 1'b1;
      @(negedge clk);
      b_start  = 1'b0;
      k = 0;
      while (!b_avail && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("b_avail", {31'd0, b_avail}, 32'd1);
      chk("b_word", b_bits, 32'h01020304);
      b_read = 1'b1;
      @(negedge clk);
      b_read = 1'b0;
      chk("b_frame_done", {31'd0, b_fdone}, 32'd1);
      chk("b_busy_clr", {31'd0, b_busy}, 32'd0);
      chk("b_nreads", b_log.size(), 32'd4);
      for (int i = 0; i < 4 && i < b_log.size(); i++)
         chk("b_addr", {15'd0, b_log[i]}, 4 + i);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
